riscv_controller: RTL and testbench
===================================

# riscv_controller

Combinational control unit of the single-cycle RV32I core: decodes the fetched instruction (opcode, funct3, funct7 bit 5) plus the ALU Zero flag into datapath controls: register/memory write enables, immediate format, ALU operand/operation, result mux select and next-PC select. It sits between instruction memory and the datapath. A small clocked section holds a sticky illegal-instruction status flag and qualifies the write enables during reset.

## Interface
- No parameters.
- clk  in  1  core clock; rising edge updates only the sticky flag.
- rst  in  1  synchronous, active-high reset.
- Instr  in  32  current instruction; uses [6:0] opcode, [14:12] funct3, [30] funct7b5.
- Zero  in  1  ALU result-equals-zero flag.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- ALUSrc  out  1  0 = rs2, 1 = immediate.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- ResultSrc  out  2  00 ALU result, 01 memory read data, 10 PC+4.
- PcSrc  out  1  1 = take branch/jump target.
- IllegalInstr  out  1  combinational: current Instr unsupported.
- IllegalSticky  out  1  registered: an unsupported Instr was seen since reset.

## Operation
- Main decoder (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump):
  - lw 0000011: 1, 00, 1, 0, 01, 0, 00, 0.
  - sw 0100011: 0, 01, 1, 1, 00, 0, 00, 0.
  - R-type 0110011: 1, 00, 0, 0, 00, 0, 10, 0.
  - branch 1100011: 0, 10, 0, 0, 00, 1, 01, 0.
  - I-ALU 0010011: 1, 00, 1, 0, 00, 0, 10, 0.
  - jal 1101111: 1, 11, 0, 0, 10, 0, 00, 1.
  - any other opcode: all zero, illegal.
- ALU decoder: ALUOp 00 -> add; 01 -> sub; 10 by funct3: 000 -> sub if R-type and Instr[30]=1, else add (addi always add); 010 slt; 001 sll; 101 srl (Instr[30] ignored); 111 and; 110 or; 100 xor; 011 -> add and illegal.
- Don't-care fields drive 0; no X is ever output.
- PcSrc = Jump | (Branch & cond); cond = Zero for funct3 000 (beq), ~Zero for 001 (bne); other branch funct3 -> cond 0 and illegal.
- lw/sw funct3 is not checked.
- Reset qualification: while rst=1, RegWrite, MemWrite, PcSrc forced 0; all other outputs still decode Instr.

## Timing
- All decode outputs are purely combinational from Instr, Zero and rst; zero-cycle latency.
- IllegalSticky: on rising clk, rst=1 -> 0; else if IllegalInstr=1 -> 1; else hold. Reset value 0. Rises the cycle after the first illegal Instr, stays high until rst.
- Reset values during rst=1: RegWrite=0, MemWrite=0, PcSrc=0, IllegalSticky=0 after the edge; others follow Instr.
- Reset asserted mid-stream: write enables drop in the same cycle; the sticky flag clears at the next edge even if IllegalInstr=1.

## Configuration
- CTRL_ILLEGAL_DET_EN defined: IllegalInstr decode and IllegalSticky register are present as described.
- Not defined: IllegalInstr and IllegalSticky are tied 0. Decode outputs are unchanged, and unsupported encodings still drive the all-zero/add defaults.

## Test plan
- rst=0, Instr opcode 0000011 (lw) -> RegWrite=1, ImmSrc=00, ALUSrc=1, MemWrite=0, ResultSrc=01, ALUControl=000, PcSrc=0; sw 0100011 -> MemWrite=1, RegWrite=0, ImmSrc=01.
- R-type sweep, funct3 000 with Instr[30]=0/1 -> ALUControl 000/001. Then 010->101, 001->110, 101->111, 111->010, 110->011, 100->100. All with RegWrite=1 and ALUSrc=0.
- Branch: beq with Zero=0/1 -> PcSrc 0/1; bne with Zero=0/1 -> PcSrc 1/0. All with ALUControl=001, ImmSrc=10, RegWrite=0.
- I-type sweep: funct3 000 with Instr[30]=1 -> add (000). Then 010 slt, 001 sll, 101 srl, 111 and, 110 or, 100 xor. All with ALUSrc=1 and RegWrite=1.
- jal 1101111 with Zero=X-free 0 -> PcSrc=1, RegWrite=1, ImmSrc=11, ResultSrc=10.
- Opcode 1111111 -> all controls 0, IllegalInstr=1, IllegalSticky=1 after the next clk edge. Then valid Instr -> sticky holds 1. Then rst=1 for one edge -> sticky 0, and RegWrite/MemWrite/PcSrc=0 while rst=1.

Source files
------------

// File: rtl/riscv_controller.sv
// Single-cycle RV32I control unit: combinational decode of Instr/Zero into datapath controls.
// Optional CTRL_ILLEGAL_DET_EN adds IllegalInstr decode and a sticky illegal flag (else both tied 0).
module riscv_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic        PcSrc,
  output logic        IllegalInstr,
  output logic        IllegalSticky
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;

  assign opcode   = Instr[6:0];
  assign funct3   = Instr[14:12];
  assign funct7b5 = Instr[30];

  logic       reg_write, mem_write, alu_src, branch, jump, opc_ill;
  logic [1:0] imm_src, result_src, alu_op;

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    opc_ill    = 1'b0;
    case (opcode)
      7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; end
      7'b0100011: begin imm_src = 2'b01; alu_src = 1'b1; mem_write = 1'b1; end
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin imm_src = 2'b10; branch = 1'b1; alu_op = 2'b01; end
      7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      7'b1101111: begin reg_write = 1'b1; imm_src = 2'b11; result_src = 2'b10; jump = 1'b1; end
      default:    opc_ill = 1'b1;
    endcase
  end

  logic [2:0] alu_ctrl;
  logic       f3_ill;
  logic       is_rtype;

  assign is_rtype = (opcode == 7'b0110011);

  // Only R-type uses bit 30 to select sub; addi and shifts ignore it.
  always_comb begin
    alu_ctrl = 3'b000;
    f3_ill   = 1'b0;
    case (alu_op)
      2'b01: alu_ctrl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctrl = (is_rtype && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b001:  alu_ctrl = 3'b110;
          3'b101:  alu_ctrl = 3'b111;
          3'b111:  alu_ctrl = 3'b010;
          3'b110:  alu_ctrl = 3'b011;
          3'b100:  alu_ctrl = 3'b100;
          default: f3_ill   = 1'b1;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

  logic br_cond, br_ill;

  always_comb begin
    br_cond = 1'b0;
    br_ill  = 1'b0;
    if (branch) begin
      case (funct3)
        3'b000:  br_cond = Zero;
        3'b001:  br_cond = ~Zero;
        default: br_ill  = 1'b1;
      endcase
    end
  end

  logic illegal_dec;
  assign illegal_dec = opc_ill | f3_ill | br_ill;

  // Architectural side effects are suppressed while reset is held.
  assign RegWrite   = reg_write & ~rst;
  assign MemWrite   = mem_write & ~rst;
  assign PcSrc      = (jump | (branch & br_cond)) & ~rst;
  assign ImmSrc     = imm_src;
  assign ALUSrc     = alu_src;
  assign ALUControl = alu_ctrl;
  assign ResultSrc  = result_src;

`ifdef CTRL_ILLEGAL_DET_EN
  logic illegal_sticky_q, illegal_sticky_d;

  always_comb begin
    illegal_sticky_d = illegal_sticky_q;
    if (illegal_dec) illegal_sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_sticky_q <= 1'b0;
    else     illegal_sticky_q <= illegal_sticky_d;
  end

  assign IllegalInstr  = illegal_dec;
  assign IllegalSticky = illegal_sticky_q;
`else
  logic unused_clk, unused_illegal;
  assign unused_clk     = clk;
  assign unused_illegal = illegal_dec;
  assign IllegalInstr   = 1'b0;
  assign IllegalSticky  = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_controller.sv
// Directed self-checking bench for riscv_controller; illegal expectations follow CTRL_ILLEGAL_DET_EN.
module tb_riscv_controller;

`ifdef CTRL_ILLEGAL_DET_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr;
  logic        Zero;
  logic        RegWrite, MemWrite, ALUSrc, PcSrc, IllegalInstr, IllegalSticky;
  logic [1:0]  ImmSrc, ResultSrc;
  logic [2:0]  ALUControl;

  int checks = 0;
  int errors = 0;

  riscv_controller dut (
    .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .ResultSrc(ResultSrc), .PcSrc(PcSrc),
    .IllegalInstr(IllegalInstr), .IllegalSticky(IllegalSticky)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic b30);
    return {1'b0, b30, 5'd0, 5'd3, 5'd2, f3, 5'd1, op};
  endfunction

  // Packs {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUControl, PcSrc}.
  function automatic logic [11:0] ctl(input logic rw, input logic [1:0] imm, input logic asrc,
                                      input logic mw, input logic [1:0] rs, input logic [2:0] alu,
                                      input logic pc);
    return {1'b0, rw, imm, asrc, mw, rs, alu, pc};
  endfunction

  task automatic apply(input logic [31:0] ins, input logic z, input logic r);
    @(negedge clk);
    Instr = ins;
    Zero  = z;
    rst   = r;
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic [11:0] exp_ctl, input logic exp_ill);
    logic [11:0] obs;
    obs = {1'b0, RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUControl, PcSrc};
    checks++;
    assert (obs === exp_ctl) else begin
      errors++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp_ctl);
    end
    checks++;
    assert (IllegalInstr === exp_ill) else begin
      errors++;
      $error("FAIL %s illegal observed=%b expected=%b", tag, IllegalInstr, exp_ill);
    end
  endtask

  task automatic check_sticky(input string tag, input logic exp_s);
    checks++;
    assert (IllegalSticky === exp_s) else begin
      errors++;
      $error("FAIL %s sticky observed=%b expected=%b", tag, IllegalSticky, exp_s);
    end
  endtask

  initial begin
    rst   = 1'b1;
    Instr = mk(OP_LW, 3'b010, 1'b0);
    Zero  = 1'b0;

    // Reset: write enables forced low, remaining fields still decode lw.
    apply(mk(OP_LW, 3'b010, 1'b0), 1'b0, 1'b1);
    check_ctl("rst_lw", ctl(0, 2'b00, 1, 0, 2'b01, 3'b000, 0), 1'b0);
    check_sticky("rst_sticky", 1'b0);

    apply(mk(OP_LW, 3'b010, 1'b0), 1'b0, 1'b0);
    check_ctl("lw", ctl(1, 2'b00, 1, 0, 2'b01, 3'b000, 0), 1'b0);
    apply(mk(OP_SW, 3'b010, 1'b0), 1'b1, 1'b0);
    check_ctl("sw", ctl(0, 2'b01, 1, 1, 2'b00, 3'b000, 0), 1'b0);

    apply(mk(OP_R, 3'b000, 1'b0), 1'b0, 1'b0);
    check_ctl("r_add", ctl(1, 2'b00, 0, 0, 2'b00, 3'b000, 0), 1'b0);
    apply(mk(OP_R, 3'b000, 1'b1), 1'b0, 1'b0);
    check_ctl("r_sub", ctl(1, 2'b00, 0, 0, 2'b00, 3'b001, 0), 1'b0);
    apply(mk(OP_R, 3'b010, 1'b0), 1'b0, 1'b0);
    check_ctl("r_slt", ctl(1, 2'b00, 0, 0, 2'b00, 3'b101, 0), 1'b0);
    apply(mk(OP_R, 3'b001, 1'b0), 1'b0, 1'b0);
    check_ctl("r_sll", ctl(1, 2'b00, 0, 0, 2'b00, 3'b110, 0), 1'b0);
    apply(mk(OP_R, 3'b101, 1'b1), 1'b0, 1'b0);
    check_ctl("r_srl_b30", ctl(1, 2'b00, 0, 0, 2'b00, 3'b111, 0), 1'b0);
    apply(mk(OP_R, 3'b111, 1'b0), 1'b0, 1'b0);
    check_ctl("r_and", ctl(1, 2'b00, 0, 0, 2'b00, 3'b010, 0), 1'b0);
    apply(mk(OP_R, 3'b110, 1'b0), 1'b0, 1'b0);
    check_ctl("r_or", ctl(1, 2'b00, 0, 0, 2'b00, 3'b011, 0), 1'b0);
    apply(mk(OP_R, 3'b100, 1'b0), 1'b0, 1'b0);
    check_ctl("r_xor", ctl(1, 2'b00, 0, 0, 2'b00, 3'b100, 0), 1'b0);
    apply(mk(OP_R, 3'b011, 1'b0), 1'b0, 1'b0);
    check_ctl("r_f3_011", ctl(1, 2'b00, 0, 0, 2'b00, 3'b000, 0), ILL);

    apply(mk(OP_BR, 3'b000, 1'b0), 1'b0, 1'b0);
    check_ctl("beq_z0", ctl(0, 2'b10, 0, 0, 2'b00, 3'b001, 0), 1'b0);
    apply(mk(OP_BR, 3'b000, 1'b0), 1'b1, 1'b0);
    check_ctl("beq_z1", ctl(0, 2'b10, 0, 0, 2'b00, 3'b001, 1), 1'b0);
    apply(mk(OP_BR, 3'b001, 1'b0), 1'b0, 1'b0);
    check_ctl("bne_z0", ctl(0, 2'b10, 0, 0, 2'b00, 3'b001, 1), 1'b0);
    apply(mk(OP_BR, 3'b001, 1'b0), 1'b1, 1'b0);
    check_ctl("bne_z1", ctl(0, 2'b10, 0, 0, 2'b00, 3'b001, 0), 1'b0);
    apply(mk(OP_BR, 3'b100, 1'b0), 1'b1, 1'b0);
    check_ctl("blt_unsup", ctl(0, 2'b10, 0, 0, 2'b00, 3'b001, 0), ILL);

    apply(mk(OP_I, 3'b000, 1'b1), 1'b0, 1'b0);
    check_ctl("addi_b30", ctl(1, 2'b00, 1, 0, 2'b00, 3'b000, 0), 1'b0);
    apply(mk(OP_I, 3'b010, 1'b0), 1'b0, 1'b0);
    check_ctl("slti", ctl(1, 2'b00, 1, 0, 2'b00, 3'b101, 0), 1'b0);
    apply(mk(OP_I, 3'b001, 1'b0), 1'b0, 1'b0);
    check_ctl("slli", ctl(1, 2'b00, 1, 0, 2'b00, 3'b110, 0), 1'b0);
    apply(mk(OP_I, 3'b101, 1'b0), 1'b0, 1'b0);
    check_ctl("srli", ctl(1, 2'b00, 1, 0, 2'b00, 3'b111, 0), 1'b0);
    apply(mk(OP_I, 3'b111, 1'b0), 1'b0, 1'b0);
    check_ctl("andi", ctl(1, 2'b00, 1, 0, 2'b00, 3'b010, 0), 1'b0);
    apply(mk(OP_I, 3'b110, 1'b0), 1'b0, 1'b0);
    check_ctl("ori", ctl(1, 2'b00, 1, 0, 2'b00, 3'b011, 0), 1'b0);
    apply(mk(OP_I, 3'b100, 1'b0), 1'b0, 1'b0);
    check_ctl("xori", ctl(1, 2'b00, 1, 0, 2'b00, 3'b100, 0), 1'b0);

    apply(mk(OP_JAL, 3'b000, 1'b0), 1'b0, 1'b0);
    check_ctl("jal", ctl(1, 2'b11, 0, 0, 2'b10, 3'b000, 1), 1'b0);
    check_sticky("sticky_clean", 1'b0);

    apply(mk(OP_BAD, 3'b000, 1'b0), 1'b1, 1'b0);
    check_ctl("bad_op", ctl(0, 2'b00, 0, 0, 2'b00, 3'b000, 0), ILL);
    check_sticky("sticky_same_cycle", 1'b0);
    apply(mk(OP_LW, 3'b010, 1'b0), 1'b0, 1'b0);
    check_sticky("sticky_set", ILL);
    apply(mk(OP_LW, 3'b010, 1'b0), 1'b0, 1'b0);
    check_sticky("sticky_hold", ILL);

    // Reset mid-stream with an illegal encoding present: flag still clears.
    apply(mk(OP_JAL, 3'b000, 1'b0), 1'b0, 1'b1);
    check_ctl("rst_jal", ctl(0, 2'b11, 0, 0, 2'b10, 3'b000, 0), 1'b0);
    check_sticky("sticky_before_rst_edge", ILL);
    apply(mk(OP_BAD, 3'b000, 1'b0), 1'b0, 1'b1);
    check_ctl("rst_bad", ctl(0, 2'b00, 0, 0, 2'b00, 3'b000, 0), ILL);
    check_sticky("sticky_cleared", 1'b0);
    apply(mk(OP_SW, 3'b010, 1'b0), 1'b0, 1'b1);
    check_ctl("rst_sw", ctl(0, 2'b01, 1, 0, 2'b00, 3'b000, 0), 1'b0);
    check_sticky("sticky_rst_over_illegal", 1'b0);
    apply(mk(OP_SW, 3'b010, 1'b0), 1'b0, 1'b0);
    check_ctl("sw_after_rst", ctl(0, 2'b01, 1, 1, 2'b00, 3'b000, 0), 1'b0);
    check_sticky("sticky_post_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
